fsm_8to64: RTL
==============

Name: fsm_8to64

Overview:
- Byte-to-block assembler directly downstream of uart2_rx.
- Collects eight consecutive received bytes (rx_out/rx_done) into one 64-bit block and presents it to the DES pipeline input with a valid/ready handshake.
- Mirror of fsm_64to8: reassembles exactly what that serializer sends.
- Adds an inter-byte timeout so that a lost byte cannot permanently misalign block boundaries.

Parameters:
- BYTES_PER_WORD, 8: bytes per assembled block. Only the value 8 is supported; data_out width is fixed at 64.
- TIMEOUT_CYCLES, 1000000: clock cycles allowed between bytes of a partial block before that block is discarded. 0 disables the timeout.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- rx_in  input  8  received byte (from uart2_rx rx_out).
- rx_done  input  1  one-cycle strobe; rx_in is valid in that cycle.
- data_out  output  64  assembled block.
- data_valid  output  1  data_out holds an untransferred block.
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
- byte_count  output  4  bytes held in the partial block (0..7).
- overrun  output  1  one-cycle pulse: a completed block was dropped.
- timeout_err  output  1  one-cycle pulse: a partial block was discarded.

Behaviour:
- Reset: sampled on the rising clock edge while reset == 0. The following registers are cleared at that edge:
  - data_out = 0, data_valid = 0, byte_count = 0, overrun = 0, timeout_err = 0
  - shift register = 0, timeout counter = 0
  - A partial block in progress is discarded.
- Byte order: the first byte received is data_out[63:56]; the eighth is data_out[7:0]. This matches the MSB-first order of fsm_64to8.
- Structure: separate assembly shift register and output register, so byte collection continues while an output block waits.
- Assembly FSM, states IDLE and COLLECT:
  - IDLE (byte_count = 0): on rx_done, shift rx_in in, set byte_count = 1, go to COLLECT.
  - COLLECT, rx_done with byte_count < 7: shift rx_in in, increment byte_count, clear the timeout counter.
  - COLLECT, rx_done with byte_count == 7 (block complete): byte_count = 0, go to IDLE, and hand the block to the output register as below.
- Block handoff:
  - If the output register is free (data_valid == 0, or data_valid && data_ready in the same cycle): data_out <= {shift[55:0], rx_in} and data_valid = 1 from the next cycle.
  - Otherwise: the completed block is dropped, data_out is unchanged, and overrun pulses high for one cycle.
- Latency: data_valid is high in the cycle after the 8th rx_done.
- Output handshake:
  - data_out is stable while data_valid is high.
  - data_valid falls in the cycle after data_valid && data_ready, unless a new block loads in that same cycle, in which case data_valid stays high and data_out updates.
  - data_ready while data_valid is low has no effect.
- Timeout:
  - The counter increments each cycle in COLLECT without rx_done.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_done:
    - The partial block is discarded: byte_count = 0, state IDLE.
    - timeout_err pulses high for one cycle.
    - The output register is unaffected.
  - rx_done in the same cycle as expiry takes priority: the byte is accepted and the counter is cleared.
  - The counter is held at 0 in IDLE.
  - TIMEOUT_CYCLES = 0: the counter never expires.
- rx_in is ignored when rx_done = 0.
- Every byte is counted; no filtering is applied.

Test Plan:
- Basic assembly: strobe bytes 0x01..0x08 with gaps of 10 cycles, data_ready = 1.
  -> data_valid is high for exactly 1 cycle, starting the cycle after the 8th strobe; data_out = 0x0102030405060708; byte_count steps 1..7 then returns to 0.
- Loopback: drive fsm_64to8 → uart2_tx → uart2_rx → fsm_8to64 with block 0x133457799BBCDFF1.
  -> data_out = 0x133457799BBCDFF1, no overrun, no timeout_err.
- Backpressure: data_ready = 0; send two blocks 0xAAAA...AA then 0x5555...55.
  -> data_out holds 0xAAAAAAAAAAAAAAAA; overrun pulses once at the 16th byte.
  -> Raise data_ready: one transfer of 0xAA..AA, then data_valid = 0.
- Simultaneous transfer and load: data_valid is high and data_ready pulses in the same cycle as the 8th byte of the next block.
  -> data_valid stays high, data_out takes the new value, no overrun.
- Timeout: TIMEOUT_CYCLES = 100; send 3 bytes, then idle for 100 cycles.
  -> timeout_err pulses once and byte_count = 0.
  -> The next 8 bytes 0x11..0x88 give data_out = 0x1122334455667788.
  -> Repeat with a byte arriving on the expiry cycle: accepted, no timeout_err.
- Reset mid-operation: after 5 bytes and with a valid block pending, assert reset = 0 for 1 cycle.
  -> All outputs read 0 after that edge.
  -> The next 8 bytes assemble a correct block with no leftover bytes.

Source files
------------

// File: rtl/fsm_8to64.sv
`default_nettype none
// ============================================================================
// Module   : fsm_8to64
// Function : Collects eight received bytes (MSB first) into a 64-bit block with
//            a valid/ready output stage and an inter-byte timeout.
// Revision : 1.0
// ============================================================================
module fsm_8to64 #(
    parameter int BYTES_PER_WORD = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_in,
    input  logic        rx_done,
    output logic [63:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [3:0]  byte_count,
    output logic        overrun,
    output logic        timeout_err
);

    localparam logic [0:0]  c_idle         = 1'b0;
    localparam logic [0:0]  c_collect      = 1'b1;
    localparam logic [3:0]  c_last_byte    = 4'(BYTES_PER_WORD - 1);
    localparam bit          c_timeout_en   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] c_timeout_last = c_timeout_en ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    logic [0:0]  r_state;
    logic [55:0] r_shift;
    logic [3:0]  r_count;
    logic [31:0] r_tcnt;
    logic [63:0] r_data;
    logic        r_valid;
    logic        r_overrun;
    logic        r_timeout;

    logic w_take;
    logic w_complete;
    logic w_expire;
    logic w_free;

    assign w_take     = r_valid && data_ready;
    assign w_complete = (r_state == c_collect) && rx_done && (r_count == c_last_byte);
    assign w_expire   = c_timeout_en && (r_tcnt == c_timeout_last);
    assign w_free     = !r_valid || w_take;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= c_idle;
            r_shift   <= '0;
            r_count   <= '0;
            r_tcnt    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                c_idle: begin
                    r_tcnt <= '0;
                    if (rx_done) begin
                        r_shift <= {r_shift[47:0], rx_in};
                        r_count <= 4'd1;
                        r_state <= c_collect;
                    end
                end
                default: begin
                    if (rx_done) begin
                        // An arriving byte always wins over a coincident expiry
                        r_tcnt <= '0;
                        if (r_count == c_last_byte) begin
                            r_count <= '0;
                            r_state <= c_idle;
                        end else begin
                            r_shift <= {r_shift[47:0], rx_in};
                            r_count <= r_count + 4'd1;
                        end
                    end else if (w_expire) begin
                        r_tcnt    <= '0;
                        r_count   <= '0;
                        r_state   <= c_idle;
                        r_timeout <= 1'b1;
                    end else if (c_timeout_en) begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
            endcase

            // Output stage can accept a new block in the same cycle it is drained
            if (w_complete) begin
                if (w_free) begin
                    r_data  <= {r_shift, rx_in};
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign byte_count  = r_count;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire
